// File: rtl/full_subtractor_cell.sv
// Single-bit full subtractor: diff = a - b - bin, with the borrow-out in bout.
module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/full_subtractor.sv
// Full subtractor with combinational and registered outputs, plus a bit-serial mode
// that chains the borrow between consecutive valid bits (LSB first, sop marks the LSB).
module full_subtractor (
  input  logic clk,
  input  logic rst,
  input  logic A,
  input  logic B,
  input  logic Bin,
  input  logic in_valid,
  input  logic serial_en,
  input  logic sop,
  output logic Difference,
  output logic Bout,
  output logic diff_q,
  output logic bout_q,
  output logic out_valid
);

  logic borrow_reg;
  logic bin_eff;

  // Mid-word serial bits take the borrow left by the previous valid bit.
  assign bin_eff = (serial_en && !sop) ? borrow_reg : Bin;

  full_subtractor_cell u_cell (
    .a    (A),
    .b    (B),
    .bin  (bin_eff),
    .diff (Difference),
    .bout (Bout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      diff_q     <= 1'b0;
      bout_q     <= 1'b0;
      out_valid  <= 1'b0;
      borrow_reg <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        diff_q     <= Difference;
        bout_q     <= Bout;
        borrow_reg <= Bout;
      end
    end
  end

endmodule

// File: tb/tb_full_subtractor.sv
// Self-checking bench for full_subtractor: directed truth-table, latency, serial-word and
// reset cases followed by randomized traffic against an arithmetic reference model.
module tb_full_subtractor;

  logic clk = 1'b0;
  logic rst, A, B, Bin, in_valid, serial_en, sop;
  logic Difference, Bout, diff_q, bout_q, out_valid;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: chained borrow and the registered outputs.
  logic m_borrow, m_dq, m_bq, m_ov;
  logic obs_d, obs_b;

  // Expected {Difference, Bout} for {A, B, Bin} = 0..7 with serial_en = 0.
  logic [1:0] truth [8] = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};

  full_subtractor dut (
    .clk        (clk),
    .rst        (rst),
    .A          (A),
    .B          (B),
    .Bin        (Bin),
    .in_valid   (in_valid),
    .serial_en  (serial_en),
    .sop        (sop),
    .Difference (Difference),
    .Bout       (Bout),
    .diff_q     (diff_q),
    .bout_q     (bout_q),
    .out_valid  (out_valid)
  );

  always #10 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One-bit subtraction done as integer arithmetic: a - b - bin.
  task automatic model_sub(input logic a, input logic b, input logic bin,
                           output logic d, output logic bo);
    int t;
    t  = int'(a) - int'(b) - int'(bin);
    bo = (t < 0);
    d  = ((t & 1) != 0);
  endtask

  // Drive one cycle of inputs, check the combinational outputs, clock, check the registers.
  task automatic apply(input logic a_v, input logic b_v, input logic bin_v, input logic iv,
                       input logic se, input logic sp, input logic r);
    logic ee, ed, eb;
    A = a_v; B = b_v; Bin = bin_v; in_valid = iv; serial_en = se; sop = sp; rst = r;
    #1;
    ee = (se && !sp) ? m_borrow : bin_v;
    model_sub(a_v, b_v, ee, ed, eb);
    obs_d = Difference;
    obs_b = Bout;
    check("comb_diff", Difference, ed);
    check("comb_bout", Bout, eb);
    @(posedge clk);
    #1;
    if (r) begin
      m_borrow = 1'b0; m_dq = 1'b0; m_bq = 1'b0; m_ov = 1'b0;
    end else begin
      m_ov = iv;
      if (iv) begin
        m_dq = ed; m_bq = eb; m_borrow = eb;
      end
    end
    check("diff_q", diff_q, m_dq);
    check("bout_q", bout_q, m_bq);
    check("out_valid", out_valid, m_ov);
  endtask

  initial begin
    logic [3:0] wa, wb;
    logic [3:0] exp_diff;
    m_borrow = 1'b0; m_dq = 1'b0; m_bq = 1'b0; m_ov = 1'b0;
    A = 0; B = 0; Bin = 0; in_valid = 0; serial_en = 0; sop = 0; rst = 1;

    // Reset state
    @(posedge clk); #1;
    check("rst_diff_q", diff_q, 1'b0);
    check("rst_bout_q", bout_q, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    rst = 0;
    @(posedge clk); #1;

    // Truth table, 1 ns apart, no clock edge in between
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      logic ed, eb;
      v = 3'(i);
      {A, B, Bin} = v;
      #1;
      model_sub(v[2], v[1], v[0], ed, eb);
      check("tt_diff", Difference, truth[i][1]);
      check("tt_bout", Bout, truth[i][0]);
      check("tt_model_diff", Difference, ed);
    end

    // One-cycle latency, then out_valid drops
    apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("lat_diff_q", diff_q, 1'b1);
    check("lat_bout_q", bout_q, 1'b1);
    check("lat_out_valid", out_valid, 1'b1);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lat_out_valid_drop", out_valid, 1'b0);
    check("lat_diff_q_hold", diff_q, 1'b1);

    // Serial 5 - 3 and 3 - 5, LSB first
    for (int w = 0; w < 2; w++) begin
      wa = (w == 0) ? 4'd5 : 4'd3;
      wb = (w == 0) ? 4'd3 : 4'd5;
      exp_diff = (w == 0) ? 4'd2 : 4'd14;
      for (int i = 0; i < 4; i++) begin
        apply(wa[i], wb[i], 1'b0, 1'b1, 1'b1, (i == 0), 1'b0);
        check("ser_diff_bit", obs_d, exp_diff[i]);
        if (i == 3) check("ser_final_bout", obs_b, (w == 1));
      end
    end

    // Reset mid-word after a borrow, chain must restart from 0
    apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("mid_borrow_gen", obs_b, 1'b1);
    apply(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    check("mid_rst_diff_q", diff_q, 1'b0);
    check("mid_rst_bout_q", bout_q, 1'b0);
    check("mid_rst_out_valid", out_valid, 1'b0);
    apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("post_rst_diff", obs_d, 1'b0);
    check("post_rst_bout", obs_b, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      apply(1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 19) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/full_subtractor.md
FULL_SUBTRACTOR -- requirements
Module: full_subtractor

Interface
- REQ-001: The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk only.
- REQ-002: Port clk, input, 1 bit: rising-edge clock.
- REQ-003: Port rst, input, 1 bit: synchronous active-high reset.
- REQ-004: Port A, input, 1 bit: minuend bit.
- REQ-005: Port B, input, 1 bit: subtrahend bit.
- REQ-006: Port Bin, input, 1 bit: external borrow-in.
- REQ-007: Port in_valid, input, 1 bit: A/B/borrow are a valid operand bit this cycle.
- REQ-008: Port serial_en, input, 1 bit: 1 = bit-serial mode, where the borrow is chained internally between consecutive valid bits.
- REQ-009: Port sop, input, 1 bit: first (LSB) bit of a serial word; qualified by in_valid.
- REQ-010: Port Difference, output, 1 bit: combinational difference bit.
- REQ-011: Port Bout, output, 1 bit: combinational borrow-out.
- REQ-012: Port diff_q, output, 1 bit: registered Difference.
- REQ-013: Port bout_q, output, 1 bit: registered Bout.
- REQ-014: Port out_valid, output, 1 bit: diff_q/bout_q hold a valid result.

Function
- REQ-015: Effective borrow bin_eff SHALL be borrow_reg when serial_en=1 and sop=0; otherwise it SHALL be Bin.
- REQ-016: Difference SHALL be A XOR B XOR bin_eff, combinational with zero latency, independent of in_valid.
- REQ-017: Bout SHALL be (NOT A AND B) OR (NOT (A XOR B) AND bin_eff), combinational with zero latency.
- REQ-018: The full truth table with serial_en=0 (A,B,Bin -> Difference,Bout) SHALL be: 000->00, 001->11, 010->11, 011->01, 100->10, 101->00, 110->00, 111->11.
- REQ-019: Combinational outputs SHALL settle without any clock edge: a change on A/B/Bin SHALL be visible on Difference/Bout in the same time step.
- REQ-020: On a clock edge with in_valid=1, the block SHALL capture diff_q<=Difference, bout_q<=Bout and out_valid<=1; this is 1-cycle latency.
- REQ-021: On a clock edge with in_valid=0, out_valid SHALL go to 0, and diff_q/bout_q SHALL hold their values.
- REQ-022: On a clock edge with in_valid=1, internal borrow_reg SHALL load Bout; with in_valid=0 it SHALL hold.
- REQ-023: sop=1 with serial_en=1 SHALL use Bin as the LSB borrow and start a new word; a sop asserted mid-word SHALL abandon the chain without error.
- REQ-024: Toggling serial_en SHALL take effect in the same cycle; borrow_reg SHALL keep updating in both modes.
- REQ-025: There is no backpressure; every valid input SHALL produce exactly one out_valid pulse one cycle later.

Reset
- REQ-026: While rst=1 at a clock edge, diff_q, bout_q, out_valid and borrow_reg SHALL all be cleared to 0, overriding in_valid.
- REQ-027: Reset SHALL NOT affect the combinational Difference/Bout, apart from borrow_reg=0 feeding bin_eff.
- REQ-028: Reset asserted mid-word SHALL lose the chain; the next serial bit without sop SHALL use borrow 0.

Structure
- REQ-029: A combinational sub-module full_subtractor_cell (inputs a, b, bin; outputs diff, bout) SHALL implement REQ-016/017, instantiated once.
- REQ-030: No shared package SHALL be required; all logic SHALL be local to the module.

Verification
- REQ-031: The bench SHALL set serial_en=0 and apply all 8 A/B/Bin combinations at 1 ns spacing with no clock edge between them, and SHALL see the outputs match the REQ-018 table each time.
- REQ-032: The bench SHALL apply A=0, B=1, Bin=0, in_valid=1 for one edge, and SHALL see diff_q=1, bout_q=1, out_valid=1 after the edge, then out_valid=0 on the next edge with in_valid=0.
- REQ-033: The bench SHALL run serial mode with serial_en=1 and compute 5-3 as 4-bit words LSB-first, A bits 1,0,1,0 and B bits 1,1,0,0, with sop on the first bit and Bin=0; the Difference sequence SHALL be 0,1,0,0 (=2) and the final Bout SHALL be 0.
- REQ-034: The bench SHALL run serial mode to compute 3-5 (A bits 1,1,0,0; B bits 1,0,1,0); the Difference sequence SHALL be 0,1,1,1 and the final Bout SHALL be 1 (underflow).
- REQ-035: The bench SHALL drive rst=1 for one edge mid-word after a borrow is generated, then send A=0, B=0, sop=0; it SHALL see Difference=0, Bout=0, and diff_q=bout_q=out_valid=0 during reset.
